// File: rtl/noc_out_port_scheduler_pkg.sv
// Shared types for the NoC output-port switch allocator.
// The widths here match the default instance parameters.
package noc_sched_pkg;
   localparam int unsigned NUM_IN_DEF   = 8;
   localparam int unsigned VC_NUM_DEF   = 4;
   localparam int unsigned VC_DEPTH_DEF = 16;
   localparam int unsigned NUM_PRIO     = 4;
   localparam int unsigned CNT_W        = $clog2(VC_DEPTH_DEF + 1);

   typedef logic [1:0]                      prio_t;
   typedef logic [$clog2(VC_NUM_DEF)-1:0]   vc_idx_t;
   typedef logic [$clog2(NUM_IN_DEF)-1:0]   port_idx_t;

   typedef enum logic {
      SCH_IDLE,
      SCH_LOCKED
   } sch_state_t;
endpackage

// File: rtl/noc_out_port_scheduler_rr_prio_pick.sv
// Round-robin picker: the first eligible input after i_ptr, searching upward with wrap.
// The result is given both as a one-hot vector and as an index.
module rr_prio_pick #(
   parameter  int unsigned N  = 8,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_elig,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_onehot,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);

   always_comb begin
      int unsigned cand;
      cand     = 0;
      o_onehot = '0;
      o_idx    = '0;
      o_valid  = 1'b0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand = (32'(i_ptr) + k) % N;
         if (!o_valid && i_elig[cand]) begin
            o_valid        = 1'b1;
            o_onehot[cand] = 1'b1;
            o_idx          = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/noc_out_port_scheduler.sv
// Switch allocator for one crossbar output port. It arbitrates by priority with round-robin
// inside each level, holds the output for a whole packet, and gates every grant on per-VC credits.
module noc_out_port_scheduler
   import noc_sched_pkg::*;
#(
   parameter  int unsigned NUM_IN   = NUM_IN_DEF,
   parameter  int unsigned VC_NUM   = VC_NUM_DEF,
   parameter  int unsigned VC_DEPTH = VC_DEPTH_DEF,
   localparam int unsigned VW       = $clog2(VC_NUM),
   localparam int unsigned PW       = $clog2(NUM_IN),
   localparam int unsigned CW       = $clog2(VC_DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_IN-1:0]      req,
   input  logic [NUM_IN*VW-1:0]   req_vc,
   input  logic [NUM_IN*2-1:0]    req_prio,
   input  logic [NUM_IN-1:0]      req_tail,
   output logic [NUM_IN-1:0]      grant,
   output logic [VW-1:0]          grant_vc,
   input  logic [VC_NUM-1:0]      credit_ret,
   output logic [VC_NUM*CW-1:0]   credit_cnt,
   output logic                   locked,
   output logic [PW-1:0]          lock_owner,
   output logic                   credit_err
);

   sch_state_t          r_state, w_state_nxt;
   logic [PW-1:0]       r_ptr, w_ptr_nxt;
   logic [PW-1:0]       r_owner, w_owner_nxt;
   logic [VW-1:0]       r_lock_vc, w_lock_vc_nxt;
   logic [CW-1:0]       r_cnt [VC_NUM];
   logic                r_credit_err;

   logic [VC_NUM-1:0]   w_has_credit;
   logic [VC_NUM-1:0]   w_consume;
   logic [NUM_IN-1:0]   w_elig     [NUM_PRIO];
   logic [NUM_IN-1:0]   w_pick_oh  [NUM_PRIO];
   logic [PW-1:0]       w_pick_idx [NUM_PRIO];
   logic [NUM_PRIO-1:0] w_pick_vld;
   logic [NUM_IN-1:0]   w_win_oh;
   logic [PW-1:0]       w_win_idx;
   logic                w_win_vld;
   logic [NUM_IN-1:0]   w_grant;
   logic [VW-1:0]       w_grant_vc;

   always_comb begin
      w_has_credit = '0;
      for (int unsigned v = 0; v < VC_NUM; v++)
         w_has_credit[v] = (r_cnt[v] != '0);
   end

   always_comb begin
      for (int unsigned l = 0; l < NUM_PRIO; l++) begin
         w_elig[l] = '0;
         for (int unsigned i = 0; i < NUM_IN; i++)
            w_elig[l][i] = req[i] && w_has_credit[req_vc[i*VW +: VW]] &&
                           (req_prio[i*2 +: 2] == prio_t'(l));
      end
   end

   for (genvar l = 0; l < NUM_PRIO; l++) begin : g_lvl
      rr_prio_pick #(.N(NUM_IN)) u_pick (
         .i_elig   (w_elig[l]),
         .i_ptr    (r_ptr),
         .o_onehot (w_pick_oh[l]),
         .o_idx    (w_pick_idx[l]),
         .o_valid  (w_pick_vld[l])
      );
   end

   // Later (higher) levels overwrite earlier ones, so the highest valid level wins
   always_comb begin
      w_win_oh  = '0;
      w_win_idx = '0;
      w_win_vld = 1'b0;
      for (int unsigned l = 0; l < NUM_PRIO; l++) begin
         if (w_pick_vld[l]) begin
            w_win_oh  = w_pick_oh[l];
            w_win_idx = w_pick_idx[l];
            w_win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_owner_nxt   = r_owner;
      w_lock_vc_nxt = r_lock_vc;
      w_grant       = '0;
      w_grant_vc    = '0;
      unique case (r_state)
         SCH_IDLE: begin
            if (w_win_vld) begin
               w_grant    = w_win_oh;
               w_grant_vc = req_vc[w_win_idx*VW +: VW];
               if (req_tail[w_win_idx]) begin
                  w_ptr_nxt = w_win_idx;
               end else begin
                  w_state_nxt   = SCH_LOCKED;
                  w_owner_nxt   = w_win_idx;
                  w_lock_vc_nxt = w_grant_vc;
               end
            end
         end
         SCH_LOCKED: begin
            w_grant_vc = r_lock_vc;
            if (req[r_owner] && w_has_credit[r_lock_vc]) begin
               w_grant[r_owner] = 1'b1;
               if (req_tail[r_owner]) begin
                  w_state_nxt = SCH_IDLE;
                  w_ptr_nxt   = r_owner;
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      w_consume = '0;
      for (int unsigned v = 0; v < VC_NUM; v++)
         w_consume[v] = (|w_grant) && (w_grant_vc == VW'(v));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= SCH_IDLE;
         r_ptr     <= PW'(NUM_IN - 1);
         r_owner   <= '0;
         r_lock_vc <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_owner   <= w_owner_nxt;
         r_lock_vc <= w_lock_vc_nxt;
      end
   end

   // A consume and a return on the same VC cancel out; a return at full depth only flags an error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_credit_err <= 1'b0;
         for (int unsigned v = 0; v < VC_NUM; v++)
            r_cnt[v] <= CW'(VC_DEPTH);
      end else begin
         for (int unsigned v = 0; v < VC_NUM; v++) begin
            if (w_consume[v] && !credit_ret[v]) begin
               r_cnt[v] <= r_cnt[v] - CW'(1);
            end else if (!w_consume[v] && credit_ret[v]) begin
               if (r_cnt[v] == CW'(VC_DEPTH))
                  r_credit_err <= 1'b1;
               else
                  r_cnt[v] <= r_cnt[v] + CW'(1);
            end
         end
      end
   end

   always_comb begin
      credit_cnt = '0;
      for (int unsigned v = 0; v < VC_NUM; v++)
         credit_cnt[v*CW +: CW] = r_cnt[v];
   end

   assign grant      = w_grant;
   assign grant_vc   = w_grant_vc;
   assign locked     = (r_state == SCH_LOCKED);
   assign lock_owner = r_owner;
   assign credit_err = r_credit_err;

endmodule

// File: tb/tb_noc_out_port_scheduler.sv
// Directed bench for noc_out_port_scheduler covering arbitration, packet locking, credits and reset.
// Inputs change 1 time unit after the rising edge, and checks run 1 time unit after that.
module tb_noc_out_port_scheduler;

   logic        clk;
   logic        rst_n;
   logic [7:0]  req;
   logic [15:0] req_vc;
   logic [15:0] req_prio;
   logic [7:0]  req_tail;
   logic [7:0]  grant;
   logic [1:0]  grant_vc;
   logic [3:0]  credit_ret;
   logic [19:0] credit_cnt;
   logic        locked;
   logic [2:0]  lock_owner;
   logic        credit_err;

   logic [1:0]  vc_a [8];
   logic [1:0]  pr_a [8];
   int          errors;
   int          checks;
   int          n;

   noc_out_port_scheduler #(.NUM_IN(8), .VC_NUM(4), .VC_DEPTH(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_vc     (req_vc),
      .req_prio   (req_prio),
      .req_tail   (req_tail),
      .grant      (grant),
      .grant_vc   (grant_vc),
      .credit_ret (credit_ret),
      .credit_cnt (credit_cnt),
      .locked     (locked),
      .lock_owner (lock_owner),
      .credit_err (credit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      req_vc   = '0;
      req_prio = '0;
      for (int i = 0; i < 8; i++) begin
         req_vc[i*2 +: 2]   = vc_a[i];
         req_prio[i*2 +: 2] = pr_a[i];
      end
   end

   function automatic logic [4:0] cnt(input int v);
      return credit_cnt[v*5 +: 5];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b0;
      req = '0;
      req_tail = '0;
      credit_ret = '0;
      for (int i = 0; i < 8; i++) begin
         vc_a[i] = '0;
         pr_a[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_grant_vc", 32'(grant_vc), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      chk("rst_owner", 32'(lock_owner), 32'h0);
      chk("rst_err", 32'(credit_err), 32'h0);
      for (int v = 0; v < 4; v++) chk("rst_cnt", 32'(cnt(v)), 32'd16);
      rst_n = 1'b1;

      // Round-robin between inputs 0 and 1 at the same priority on VC0
      req = 8'h03; req_tail = 8'h03;
      #1 chk("rr_c1", 32'(grant), 32'h01);
      chk("rr_c1_vc", 32'(grant_vc), 32'h0);
      step(); #1 chk("rr_c2", 32'(grant), 32'h02);
      step(); #1 chk("rr_c3", 32'(grant), 32'h01);
      step(); #1 chk("rr_c4", 32'(grant), 32'h02);
      step(); req = '0;
      #1 chk("rr_idle", 32'(grant), 32'h0);
      chk("rr_cnt0", 32'(cnt(0)), 32'd12);
      credit_ret = 4'b0001;
      repeat (4) step();
      credit_ret = '0;
      #1 chk("ret_cnt0", 32'(cnt(0)), 32'd16);

      // A higher priority level beats a lower one
      pr_a[2] = 2'd3; pr_a[5] = 2'd1;
      req = 8'h24; req_tail = 8'h24;
      #1 chk("prio_c1", 32'(grant), 32'h04);
      step(); #1 chk("prio_c2", 32'(grant), 32'h04);
      step(); #1 chk("prio_c3", 32'(grant), 32'h04);
      step(); req[2] = 1'b0;
      #1 chk("prio_low", 32'(grant), 32'h20);
      step(); req = '0; pr_a[2] = '0; pr_a[5] = '0;
      #1 chk("prio_cnt0", 32'(cnt(0)), 32'd12);

      // 3-flit packet from input 4 on VC2 while input 1 waits
      vc_a[4] = 2'd2; pr_a[4] = 2'd2; vc_a[1] = 2'd0; pr_a[1] = 2'd0;
      req_tail = 8'h02; req = 8'h12;
      #1 chk("pkt_head", 32'(grant), 32'h10);
      chk("pkt_head_vc", 32'(grant_vc), 32'h2);
      chk("pkt_head_lock", 32'(locked), 32'h0);
      step(); vc_a[4] = 2'd3; pr_a[4] = 2'd0;
      #1 chk("pkt_body", 32'(grant), 32'h10);
      chk("pkt_body_vc", 32'(grant_vc), 32'h2);
      chk("pkt_body_lock", 32'(locked), 32'h1);
      chk("pkt_body_owner", 32'(lock_owner), 32'h4);
      step(); req_tail[4] = 1'b1;
      #1 chk("pkt_tail", 32'(grant), 32'h10);
      chk("pkt_tail_lock", 32'(locked), 32'h1);
      step(); req[4] = 1'b0; req_tail[4] = 1'b0;
      #1 chk("pkt_after_lock", 32'(locked), 32'h0);
      chk("pkt_after_grant", 32'(grant), 32'h02);
      step(); req = '0; req_tail = '0;
      #1 chk("pkt_cnt2", 32'(cnt(2)), 32'd13);
      chk("pkt_cnt0", 32'(cnt(0)), 32'd11);

      // Drain VC1 with no credit returns, then return one credit
      vc_a[0] = 2'd1; req_tail = 8'h01; req = 8'h01;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         #1 if (grant[0]) n++;
         step();
      end
      chk("drain_grants", 32'(n), 32'd16);
      #1 chk("drain_cnt1", 32'(cnt(1)), 32'd0);
      chk("drain_grant", 32'(grant), 32'h0);
      credit_ret = 4'b0010;
      step(); credit_ret = '0;
      n = 0;
      for (int c = 0; c < 5; c++) begin
         #1 if (grant[0]) n++;
         step();
      end
      chk("one_credit_grants", 32'(n), 32'd1);
      #1 chk("one_credit_cnt1", 32'(cnt(1)), 32'd0);
      req = '0; req_tail = '0;

      // Credit return at full depth saturates and sets the sticky error
      chk("pre_err", 32'(credit_err), 32'h0);
      credit_ret = 4'b1000;
      step(); credit_ret = '0;
      #1 chk("sat_cnt3", 32'(cnt(3)), 32'd16);
      chk("sat_err", 32'(credit_err), 32'h1);

      // Bring VC3 down to 5, then consume and return on the same cycle
      vc_a[3] = 2'd3; req_tail = 8'h08; req = 8'h08;
      repeat (11) step();
      req = '0;
      #1 chk("vc3_at5", 32'(cnt(3)), 32'd5);
      step(); req = 8'h08; credit_ret = 4'b1000;
      #1 chk("net_grant", 32'(grant), 32'h08);
      chk("net_grant_vc", 32'(grant_vc), 32'h3);
      step(); req = '0; credit_ret = '0; req_tail = '0;
      #1 chk("net_cnt3", 32'(cnt(3)), 32'd5);
      chk("err_sticky", 32'(credit_err), 32'h1);

      // Reset in the middle of a packet
      vc_a[6] = 2'd0; pr_a[6] = 2'd0; req = 8'h40;
      #1 chk("mid_head", 32'(grant), 32'h40);
      step();
      #1 chk("mid_locked", 32'(locked), 32'h1);
      chk("mid_owner", 32'(lock_owner), 32'h6);
      rst_n = 1'b0; req = '0;
      #1 chk("mid_rst_locked", 32'(locked), 32'h0);
      chk("mid_rst_grant", 32'(grant), 32'h0);
      chk("mid_rst_owner", 32'(lock_owner), 32'h0);
      chk("mid_rst_err", 32'(credit_err), 32'h0);
      for (int v = 0; v < 4; v++) chk("mid_rst_cnt", 32'(cnt(v)), 32'd16);
      step(); rst_n = 1'b1;
      vc_a[0] = 2'd0; vc_a[1] = 2'd0; req_tail = 8'h03; req = 8'h03;
      #1 chk("post_rst_tie", 32'(grant), 32'h01);
      chk("post_rst_vc", 32'(grant_vc), 32'h0);
      step(); req = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/noc_out_port_scheduler.md
Name: noc_out_port_scheduler

Overview:
- Per-output-port switch allocator for the NoC crossbar.
- Arbitrates among NUM_IN input requesters using 2-bit priority, with round-robin inside each priority level.
- Locks the output to one input for the whole packet (head to tail) and gates every grant on downstream per-VC credits.
- Drives the one-hot select column for one crossbar output; one instance per output port.

Parameters:
NUM_IN, 8, number of input requesters competing for this output
VC_NUM, 4, virtual channels on the output link (power of 2)
VC_DEPTH, 16, downstream buffer depth per VC = initial credit count

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_IN  per-input flit-ready request, held until granted
req_vc  in  NUM_IN*log2(VC_NUM)  target VC per input, flattened, input i at [i*VW +: VW]
req_prio  in  NUM_IN*2  priority per input, 3 = highest
req_tail  in  NUM_IN  flit offered by input i is a packet tail (head+tail = single-flit packet)
grant  out  NUM_IN  one-hot grant = crossbar select column; flit transfers in the grant cycle
grant_vc  out  log2(VC_NUM)  VC of granted flit
credit_ret  in  VC_NUM  per-VC credit-return pulse from downstream, 1 credit each
credit_cnt  out  VC_NUM*$clog2(VC_DEPTH+1)  current credit counters, flattened
locked  out  1  packet in progress; output owned by lock_owner
lock_owner  out  log2(NUM_IN)  current owner, valid when locked=1
credit_err  out  1  sticky: credit return while counter already at VC_DEPTH

Behaviour:
- Reset values: state IDLE, grant=0, grant_vc=0, locked=0, lock_owner=0, credit_err=0, all credit_cnt=VC_DEPTH, RR pointer=NUM_IN-1 (input 0 wins the first tie).
- Grant timing: grant is combinational from registered state and current inputs, so latency is 0 cycles. The requester sees grant[i] and drops or advances its flit on the next edge.
- Eligibility: input i is eligible iff req[i]=1 and credit_cnt[vc_i]>0.
  - IDLE: vc_i = req_vc[i].
  - LOCKED: vc_i = the latched VC.
- IDLE arbitration:
  - Select the highest req_prio level that has any eligible input.
  - Within that level, winner = first eligible input after the RR pointer, searching upward with wrap.
  - Outputs: grant[winner]=1, grant_vc=req_vc[winner].
- IDLE transitions:
  - Winner with req_tail=1: stay IDLE, pointer <= winner.
  - Winner with req_tail=0: go LOCKED, latch owner=winner and vc; pointer unchanged.
- LOCKED:
  - Only the owner is considered; all other inputs get grant=0 regardless of priority.
  - grant[owner]=1 iff req[owner] and credit>0 on the latched VC.
  - Owner deasserting req, or running out of credit, stalls the lock with no grant and no timeout.
  - req_vc/req_prio of the owner are ignored while locked.
  - Granted tail: go IDLE, pointer <= owner, locked drops the next cycle.
- Credits:
  - A granted flit decrements credit_cnt[grant_vc].
  - credit_ret[v] increments credit_cnt[v].
  - Consume and return on the same VC in the same cycle: net unchanged.
  - Return at VC_DEPTH (with no simultaneous consume): counter saturates and credit_err sets. credit_err clears only by reset.
  - A counter never goes below 0, because a grant requires credit>0.
- Counter width: $clog2(VC_DEPTH+1); arithmetic is unsigned, no wrap.
- Reset mid-packet: lock aborted, counters return to VC_DEPTH. Upstream/downstream are reset together.
- Invariant: grant is always one-hot or zero. A nonzero grant is legal only when the granted input's req=1.

Decomposition:
- Package noc_sched_pkg holds:
  - typedefs prio_t (2b), vc_idx_t, port_idx_t
  - state enum {SCH_IDLE, SCH_LOCKED}
  - localparam CNT_W
- Sub-module rr_prio_pick: combinational rotate + priority-encode. Inputs are an eligible vector and a pointer; outputs are a one-hot vector and an index. It is instantiated once per priority level (4 copies), followed by a highest-level mux.

Test Plan:
- Reset, then req=0b0000_0011, both prio 0, single-flit, VC0 → grant 0b01 in cycle 1, then 0b10 in cycle 2; the pattern alternates while both are held.
- Input 2 prio 3 and input 5 prio 1, both requesting single-flit packets → input 2 is granted every cycle until it drops req; input 5 is never granted meanwhile.
- Input 4 sends a 3-flit packet on VC2 while input 1 requests continuously → grant=input 4 for three cycles, locked=1 and lock_owner=4 during the packet; input 1 is granted the cycle after the tail.
- Input 0 streams single flits on VC1 with no credit_ret → exactly 16 grants, then credit_cnt[VC1]=0 and grant=0. One credit_ret[1] pulse → exactly one further grant.
- Counter at 5, grant on VC3 with credit_ret[3]=1 in the same cycle → count stays 5.
- Counter at VC_DEPTH, extra credit_ret → count stays 16 and credit_err=1 until reset.
- Assert rst_n low mid-packet while locked → locked=0, grant=0, all counters=16. After release, input 0 wins the first tie.
